dot_acc_array: RTL

DOT_ACC_ARRAY -- requirements
Module: dot_acc_array

---
 rtl/dot_acc_array_pkg.sv | 20 ++
 rtl/dot_acc_array_lane_mac.sv | 58 +++++
 rtl/dot_acc_array.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dot_acc_array_pkg.sv
// Shared definitions for the dot_acc_array block.
// Holds the FSM state encoding, the default parameter widths and a helper
// that sizes the cross-lane sum output.
package dot_acc_array_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefParaDeg   = 4;
  localparam int unsigned DefAccWidth  = 2 * DefDataWidth + 8;
  localparam int unsigned DefCntWidth  = 8;

  // FSM encoding: accept beats in StAcc, present the result in StDone.
  localparam logic [0:0] StAcc  = 1'b0;
  localparam logic [0:0] StDone = 1'b1;

  // Width of the sum of `lanes` values of `acc_w` bits, with no overflow.
  function automatic int unsigned sum_width(int unsigned acc_w, int unsigned lanes);
    return acc_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/dot_acc_array_lane_mac.sv
// lane_mac: one multiply-accumulate lane of dot_acc_array.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   beat_en           - an operand beat is accepted this cycle
//   first             - the accepted beat is the first of a vector
//   mode              - effective signed mode for this beat (1 = two's complement)
//   bias_en, bias     - initial accumulator value select / value for a first beat
//   a, b              - lane operands
//   acc               - registered accumulator
module lane_mac #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Acc_Width  = 2 * Data_Width + 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  beat_en,
  input  logic                  first,
  input  logic                  mode,
  input  logic                  bias_en,
  input  logic [Data_Width-1:0] a,
  input  logic [Data_Width-1:0] b,
  input  logic [Acc_Width-1:0]  bias,
  output logic [Acc_Width-1:0]  acc
);

  localparam int unsigned ExtWidth = Acc_Width - Data_Width;

  logic [Acc_Width-1:0] a_ext;
  logic [Acc_Width-1:0] b_ext;
  logic [Acc_Width-1:0] prod;
  logic [Acc_Width-1:0] base;
  logic [Acc_Width-1:0] acc_d;
  logic [Acc_Width-1:0] acc_q;

  // Extending both operands to Acc_Width before multiplying yields the full
  // 2*Data_Width product already sign/zero-extended, modulo 2^Acc_Width.
  always_comb begin
    a_ext = {{ExtWidth{mode & a[Data_Width-1]}}, a};
    b_ext = {{ExtWidth{mode & b[Data_Width-1]}}, b};
    prod  = a_ext * b_ext;
    base  = first ? (bias_en ? bias : '0) : acc_q;
    acc_d = acc_q;
    if (beat_en) begin
      acc_d = base + prod;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dot_acc_array.sv
// dot_acc_array: Para_Deg-lane dot-product accumulator with valid/ready
// handshakes on both sides.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   in_valid/in_ready     - operand beat handshake; in_last marks the final beat
//   data0, data1          - packed lane operands, lane i at [Data_Width*i +: Data_Width]
//   signed_mode, bias_en  - per-vector controls, sampled on the first beat
//   bias                  - packed per-lane initial accumulator values
//   out_valid/out_ready   - result handshake
//   result, result_sum    - per-lane accumulators and their extended sum
//   beat_count, cnt_ovf   - beats in the vector, and counter saturation flag
module dot_acc_array
  import dot_acc_array_pkg::*;
#(
  parameter int unsigned Data_Width = DefDataWidth,
  parameter int unsigned Para_Deg   = DefParaDeg,
  parameter int unsigned Acc_Width  = 2 * Data_Width + 8,
  parameter int unsigned Cnt_Width  = DefCntWidth
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_last,
  input  logic [Para_Deg*Data_Width-1:0]     data0,
  input  logic [Para_Deg*Data_Width-1:0]     data1,
  input  logic                               signed_mode,
  input  logic                               bias_en,
  input  logic [Para_Deg*Acc_Width-1:0]      bias,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [Para_Deg*Acc_Width-1:0]      result,
  output logic [sum_width(Acc_Width, Para_Deg)-1:0] result_sum,
  output logic [Cnt_Width-1:0]               beat_count,
  output logic                               cnt_ovf
);

  localparam int unsigned SumWidth = sum_width(Acc_Width, Para_Deg);
  localparam logic [Cnt_Width-1:0] CntMax = {Cnt_Width{1'b1}};

  logic [0:0]           state_d, state_q;
  logic                 first_d, first_q;
  logic                 mode_d, mode_q;
  logic [Cnt_Width-1:0] cnt_d, cnt_q;
  logic                 ovf_d, ovf_q;

  logic accept;
  logic mode_eff;
  logic [SumWidth-1:0] lane_ext [Para_Deg];

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid & in_ready;
  // The first beat uses the live mode input; later beats use the latched copy.
  assign mode_eff  = first_q ? signed_mode : mode_q;

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (accept) begin
      first_d = 1'b0;
      if (first_q) begin
        mode_d = signed_mode;
        cnt_d  = Cnt_Width'(1);
        ovf_d  = 1'b0;
      end else if (cnt_q == CntMax) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (in_last) begin
        state_d = StDone;
      end
    end else if (out_valid && out_ready) begin
      state_d = StAcc;
      first_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StAcc;
      first_q <= 1'b1;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar g = 0; g < Para_Deg; g++) begin : g_lane
    lane_mac #(
      .Data_Width(Data_Width),
      .Acc_Width (Acc_Width)
    ) u_lane_mac (
      .clk    (clk),
      .reset  (reset),
      .beat_en(accept),
      .first  (first_q),
      .mode   (mode_eff),
      .bias_en(bias_en),
      .a      (data0[g*Data_Width +: Data_Width]),
      .b      (data1[g*Data_Width +: Data_Width]),
      .bias   (bias[g*Acc_Width +: Acc_Width]),
      .acc    (result[g*Acc_Width +: Acc_Width])
    );

    assign lane_ext[g] = {{(SumWidth - Acc_Width){mode_q & result[(g+1)*Acc_Width-1]}},
                          result[g*Acc_Width +: Acc_Width]};
  end

  always_comb begin
    result_sum = '0;
    for (int i = 0; i < Para_Deg; i++) begin
      result_sum = result_sum + lane_ext[i];
    end
  end

  assign beat_count = cnt_q;
  assign cnt_ovf    = ovf_q;

endmodule
